// File: rtl/scr1_axi_rd_arb.sv
// Merges the SCR1 IMEM and DMEM AXI4 read channels into one read master with per-source outstanding limits.
// Define SCR1_AXI_ARB_DMEM_PRIO_EN for fixed DMEM priority; otherwise arbitration is round-robin.
module scr1_axi_rd_arb #(
    parameter int IMEM_ID_W = 3,
    parameter int DMEM_ID_W = 2,
    parameter int MAX_OUTST = 4,
    localparam int M_ID_W   = ((IMEM_ID_W > DMEM_ID_W) ? IMEM_ID_W : DMEM_ID_W) + 1
) (
    input  logic                 clk_riscv,
    input  logic                 reset,
    input  logic [IMEM_ID_W-1:0] imem_arid,
    input  logic [31:0]          imem_araddr,
    input  logic [7:0]           imem_arlen,
    input  logic [2:0]           imem_arsize,
    input  logic [1:0]           imem_arburst,
    input  logic                 imem_arvalid,
    output logic                 imem_arready,
    output logic [IMEM_ID_W-1:0] imem_rid,
    output logic [31:0]          imem_rdata,
    output logic [1:0]           imem_rresp,
    output logic                 imem_rlast,
    output logic                 imem_rvalid,
    input  logic                 imem_rready,
    input  logic [DMEM_ID_W-1:0] dmem_arid,
    input  logic [31:0]          dmem_araddr,
    input  logic [7:0]           dmem_arlen,
    input  logic [2:0]           dmem_arsize,
    input  logic [1:0]           dmem_arburst,
    input  logic                 dmem_arvalid,
    output logic                 dmem_arready,
    output logic [DMEM_ID_W-1:0] dmem_rid,
    output logic [31:0]          dmem_rdata,
    output logic [1:0]           dmem_rresp,
    output logic                 dmem_rlast,
    output logic                 dmem_rvalid,
    input  logic                 dmem_rready,
    output logic [M_ID_W-1:0]    m_arid,
    output logic [31:0]          m_araddr,
    output logic [7:0]           m_arlen,
    output logic [2:0]           m_arsize,
    output logic [1:0]           m_arburst,
    output logic                 m_arvalid,
    input  logic                 m_arready,
    input  logic [M_ID_W-1:0]    m_rid,
    input  logic [31:0]          m_rdata,
    input  logic [1:0]           m_rresp,
    input  logic                 m_rlast,
    input  logic                 m_rvalid,
    output logic                 m_rready
);

    localparam int CNT_W = $clog2(MAX_OUTST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                   input logic inc, input logic dec);
        logic [CNT_W-1:0] v;
        v = cnt;
        if (inc) v = v + CNT_W'(1);
        // An rlast with nothing outstanding is a protocol error; hold at zero.
        if (dec && (cnt != '0)) v = v - CNT_W'(1);
        return v;
    endfunction

    logic                 r_arvalid;
    logic [M_ID_W-1:0]    r_arid;
    logic [31:0]          r_araddr;
    logic [7:0]           r_arlen;
    logic [2:0]           r_arsize;
    logic [1:0]           r_arburst;
    logic [CNT_W-1:0]     r_cnt_imem;
    logic [CNT_W-1:0]     r_cnt_dmem;

    logic                 w_free;
    logic                 w_elig_imem;
    logic                 w_elig_dmem;
    logic                 w_gnt_imem;
    logic                 w_gnt_dmem;
    logic                 w_src;
    logic                 w_dec_imem;
    logic                 w_dec_dmem;
    logic [M_ID_W-2:0]    w_imem_id_ext;
    logic [M_ID_W-2:0]    w_dmem_id_ext;

    assign w_free        = ~r_arvalid | m_arready;
    assign w_elig_imem   = imem_arvalid & (r_cnt_imem < MAX_CNT);
    assign w_elig_dmem   = dmem_arvalid & (r_cnt_dmem < MAX_CNT);
    assign w_imem_id_ext = (M_ID_W-1)'(imem_arid);
    assign w_dmem_id_ext = (M_ID_W-1)'(dmem_arid);

`ifndef SCR1_AXI_ARB_DMEM_PRIO_EN
    logic r_last_dmem;

    always_ff @(posedge clk_riscv) begin
        if (reset)           r_last_dmem <= 1'b1;
        else if (w_gnt_imem) r_last_dmem <= 1'b0;
        else if (w_gnt_dmem) r_last_dmem <= 1'b1;
    end
`endif

    always_comb begin
        w_gnt_imem = 1'b0;
        w_gnt_dmem = 1'b0;
        if (w_free) begin
`ifdef SCR1_AXI_ARB_DMEM_PRIO_EN
            w_gnt_dmem = w_elig_dmem;
            w_gnt_imem = w_elig_imem & ~w_elig_dmem;
`else
            if (w_elig_imem & w_elig_dmem) begin
                w_gnt_imem = r_last_dmem;
                w_gnt_dmem = ~r_last_dmem;
            end else begin
                w_gnt_imem = w_elig_imem;
                w_gnt_dmem = w_elig_dmem;
            end
`endif
        end
    end

    assign imem_arready = w_gnt_imem;
    assign dmem_arready = w_gnt_dmem;

    // AR slice: reloads only when empty or being drained, so fields stay stable under backpressure.
    always_ff @(posedge clk_riscv) begin
        if (reset) begin
            r_arvalid <= 1'b0;
            r_arid    <= '0;
            r_araddr  <= '0;
            r_arlen   <= '0;
            r_arsize  <= '0;
            r_arburst <= '0;
        end else if (w_free) begin
            r_arvalid <= w_gnt_imem | w_gnt_dmem;
            if (w_gnt_imem) begin
                r_arid    <= {1'b0, w_imem_id_ext};
                r_araddr  <= imem_araddr;
                r_arlen   <= imem_arlen;
                r_arsize  <= imem_arsize;
                r_arburst <= imem_arburst;
            end else if (w_gnt_dmem) begin
                r_arid    <= {1'b1, w_dmem_id_ext};
                r_araddr  <= dmem_araddr;
                r_arlen   <= dmem_arlen;
                r_arsize  <= dmem_arsize;
                r_arburst <= dmem_arburst;
            end
        end
    end

    assign m_arvalid = r_arvalid;
    assign m_arid    = r_arid;
    assign m_araddr  = r_araddr;
    assign m_arlen   = r_arlen;
    assign m_arsize  = r_arsize;
    assign m_arburst = r_arburst;

    // R routing is purely combinational on the source bit of the returned ID.
    assign w_src       = m_rid[M_ID_W-1];
    assign imem_rvalid = m_rvalid & ~w_src;
    assign dmem_rvalid = m_rvalid & w_src;
    assign imem_rid    = m_rid[IMEM_ID_W-1:0];
    assign dmem_rid    = m_rid[DMEM_ID_W-1:0];
    assign imem_rdata  = m_rdata;
    assign dmem_rdata  = m_rdata;
    assign imem_rresp  = m_rresp;
    assign dmem_rresp  = m_rresp;
    assign imem_rlast  = m_rlast;
    assign dmem_rlast  = m_rlast;
    assign m_rready    = w_src ? dmem_rready : imem_rready;

    assign w_dec_imem = imem_rvalid & imem_rready & m_rlast;
    assign w_dec_dmem = dmem_rvalid & dmem_rready & m_rlast;

    always_ff @(posedge clk_riscv) begin
        if (reset) begin
            r_cnt_imem <= '0;
            r_cnt_dmem <= '0;
        end else begin
            r_cnt_imem <= cnt_next(r_cnt_imem, w_gnt_imem, w_dec_imem);
            r_cnt_dmem <= cnt_next(r_cnt_dmem, w_gnt_dmem, w_dec_dmem);
        end
    end

`ifndef SYNTHESIS
    a_imem_underflow: assert property (@(posedge clk_riscv) disable iff (reset)
        !(w_dec_imem && (r_cnt_imem == '0)));
    a_dmem_underflow: assert property (@(posedge clk_riscv) disable iff (reset)
        !(w_dec_dmem && (r_cnt_dmem == '0)));
`endif

endmodule

// File: tb/tb_scr1_axi_rd_arb.sv
// Directed testbench for scr1_axi_rd_arb: reset, single burst, arbitration, limits, backpressure, R routing.
module tb_scr1_axi_rd_arb;

    logic        clk_riscv = 1'b0;
    logic        reset;
    logic [2:0]  imem_arid;
    logic [31:0] imem_araddr;
    logic [7:0]  imem_arlen;
    logic [2:0]  imem_arsize;
    logic [1:0]  imem_arburst;
    logic        imem_arvalid;
    logic        imem_arready;
    logic [2:0]  imem_rid;
    logic [31:0] imem_rdata;
    logic [1:0]  imem_rresp;
    logic        imem_rlast;
    logic        imem_rvalid;
    logic        imem_rready;
    logic [1:0]  dmem_arid;
    logic [31:0] dmem_araddr;
    logic [7:0]  dmem_arlen;
    logic [2:0]  dmem_arsize;
    logic [1:0]  dmem_arburst;
    logic        dmem_arvalid;
    logic        dmem_arready;
    logic [1:0]  dmem_rid;
    logic [31:0] dmem_rdata;
    logic [1:0]  dmem_rresp;
    logic        dmem_rlast;
    logic        dmem_rvalid;
    logic        dmem_rready;
    logic [3:0]  m_arid;
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic        m_arvalid;
    logic        m_arready;
    logic [3:0]  m_rid;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rlast;
    logic        m_rvalid;
    logic        m_rready;

    int checks = 0;
    int errors = 0;

    always #5 clk_riscv = ~clk_riscv;

    scr1_axi_rd_arb dut (
        .clk_riscv(clk_riscv), .reset(reset),
        .imem_arid(imem_arid), .imem_araddr(imem_araddr), .imem_arlen(imem_arlen),
        .imem_arsize(imem_arsize), .imem_arburst(imem_arburst),
        .imem_arvalid(imem_arvalid), .imem_arready(imem_arready),
        .imem_rid(imem_rid), .imem_rdata(imem_rdata), .imem_rresp(imem_rresp),
        .imem_rlast(imem_rlast), .imem_rvalid(imem_rvalid), .imem_rready(imem_rready),
        .dmem_arid(dmem_arid), .dmem_araddr(dmem_araddr), .dmem_arlen(dmem_arlen),
        .dmem_arsize(dmem_arsize), .dmem_arburst(dmem_arburst),
        .dmem_arvalid(dmem_arvalid), .dmem_arready(dmem_arready),
        .dmem_rid(dmem_rid), .dmem_rdata(dmem_rdata), .dmem_rresp(dmem_rresp),
        .dmem_rlast(dmem_rlast), .dmem_rvalid(dmem_rvalid), .dmem_rready(dmem_rready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    task automatic tick();
        @(posedge clk_riscv);
        #1;
    endtask

    task automatic idle_inputs();
        imem_arid = '0; imem_araddr = '0; imem_arlen = '0; imem_arsize = '0; imem_arburst = '0;
        imem_arvalid = 1'b0; imem_rready = 1'b0;
        dmem_arid = '0; dmem_araddr = '0; dmem_arlen = '0; dmem_arsize = '0; dmem_arburst = '0;
        dmem_arvalid = 1'b0; dmem_rready = 1'b0;
        m_arready = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b1;
        #1;
        checks++; if (m_arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid got=%b want=0", m_arvalid); end
        checks++; if (imem_arready !== 1'b0) begin errors++; $display("FAIL reset_imem_arready got=%b want=0", imem_arready); end
        checks++; if (dmem_arready !== 1'b0) begin errors++; $display("FAIL reset_dmem_arready got=%b want=0", dmem_arready); end
        checks++; if (m_rready !== 1'b0) begin errors++; $display("FAIL reset_rready got=%b want=0", m_rready); end
        checks++; if ({m_arid, m_araddr, m_arlen} !== 44'h0) begin errors++; $display("FAIL reset_fields got=%h/%h/%h want=0", m_arid, m_araddr, m_arlen); end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_single_imem();
        do_reset();
        m_arready = 1'b1;
        imem_arid = 3'd5; imem_araddr = 32'h0000_0200; imem_arlen = 8'd3;
        imem_arsize = 3'd2; imem_arburst = 2'd1; imem_arvalid = 1'b1;
        #1;
        checks++; if (imem_arready !== 1'b1) begin errors++; $display("FAIL single_arready got=%b want=1", imem_arready); end
        checks++; if (m_arvalid !== 1'b0) begin errors++; $display("FAIL single_latency got=%b want=0", m_arvalid); end
        tick();
        imem_arvalid = 1'b0;
        checks++; if (m_arvalid !== 1'b1) begin errors++; $display("FAIL single_arvalid got=%b want=1", m_arvalid); end
        checks++; if (m_arid !== 4'b0101) begin errors++; $display("FAIL single_arid got=%b want=0101", m_arid); end
        checks++; if (m_araddr !== 32'h200) begin errors++; $display("FAIL single_araddr got=%h want=200", m_araddr); end
        checks++; if ({m_arlen, m_arsize, m_arburst} !== {8'd3, 3'd2, 2'd1}) begin errors++; $display("FAIL single_arctl got=%h/%h/%h want=3/2/1", m_arlen, m_arsize, m_arburst); end
        tick();
        checks++; if (m_arvalid !== 1'b0) begin errors++; $display("FAIL single_drain got=%b want=0", m_arvalid); end
        imem_rready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m_rvalid = 1'b1; m_rid = 4'b0101; m_rdata = 32'hA000_0000 + i; m_rresp = 2'd0; m_rlast = (i == 3);
            #1;
            checks++; if (imem_rvalid !== 1'b1 || dmem_rvalid !== 1'b0) begin errors++; $display("FAIL single_rvalid beat=%0d got=%b/%b want=1/0", i, imem_rvalid, dmem_rvalid); end
            checks++; if (imem_rid !== 3'd5 || imem_rdata !== 32'hA000_0000 + i || imem_rlast !== (i == 3)) begin errors++; $display("FAIL single_rbeat beat=%0d got=%0d/%h/%b", i, imem_rid, imem_rdata, imem_rlast); end
            checks++; if (m_rready !== 1'b1) begin errors++; $display("FAIL single_rready beat=%0d got=%b want=1", i, m_rready); end
            tick();
        end
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #1;
        checks++; if (dut.r_cnt_imem !== '0) begin errors++; $display("FAIL single_cnt got=%0d want=0", dut.r_cnt_imem); end
    endtask

    task automatic test_arbitration();
        logic exp_imem;
        do_reset();
        m_arready = 1'b1;
        imem_arid = 3'd1; imem_araddr = 32'h1000; imem_arvalid = 1'b1;
        dmem_arid = 2'd2; dmem_araddr = 32'h2000; dmem_arvalid = 1'b1;
        for (int k = 0; k < 8; k++) begin
`ifdef SCR1_AXI_ARB_DMEM_PRIO_EN
            exp_imem = (k >= 4);
`else
            exp_imem = (k % 2 == 0);
`endif
            #1;
            checks++; if (imem_arready !== exp_imem || dmem_arready !== !exp_imem) begin errors++; $display("FAIL arb_grant k=%0d got=%b/%b want=%b/%b", k, imem_arready, dmem_arready, exp_imem, !exp_imem); end
            tick();
            checks++; if (m_arvalid !== 1'b1 || m_arid !== (exp_imem ? 4'b0001 : 4'b1010)) begin errors++; $display("FAIL arb_arid k=%0d got=%b/%b", k, m_arvalid, m_arid); end
        end
        #1;
        checks++; if (imem_arready !== 1'b0 || dmem_arready !== 1'b0) begin errors++; $display("FAIL arb_limit got=%b/%b want=0/0", imem_arready, dmem_arready); end
        imem_arvalid = 1'b0; dmem_arvalid = 1'b0;
    endtask

    task automatic test_outstanding();
        do_reset();
        m_arready = 1'b1;
        imem_arvalid = 1'b1; imem_arid = 3'd0;
        for (int k = 0; k < 4; k++) begin
            imem_araddr = 32'h3000 + 32'(k * 16);
            #1;
            checks++; if (imem_arready !== 1'b1) begin errors++; $display("FAIL outst_accept k=%0d got=%b want=1", k, imem_arready); end
            tick();
        end
        imem_araddr = 32'h3040;
        #1;
        checks++; if (imem_arready !== 1'b0) begin errors++; $display("FAIL outst_block got=%b want=0", imem_arready); end
        tick();
        checks++; if (imem_arready !== 1'b0 || m_arvalid !== 1'b0) begin errors++; $display("FAIL outst_hold got=%b/%b want=0/0", imem_arready, m_arvalid); end
        imem_rready = 1'b1; m_rvalid = 1'b1; m_rid = 4'b0000; m_rlast = 1'b1;
        tick();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #1;
        checks++; if (imem_arready !== 1'b1) begin errors++; $display("FAIL outst_release got=%b want=1", imem_arready); end
        tick();
        imem_arvalid = 1'b0;
        checks++; if (m_arvalid !== 1'b1 || m_araddr !== 32'h3040) begin errors++; $display("FAIL outst_issue got=%b/%h want=1/3040", m_arvalid, m_araddr); end
        checks++; if (dut.r_cnt_imem !== 3'd4) begin errors++; $display("FAIL outst_cnt got=%0d want=4", dut.r_cnt_imem); end
        imem_rready = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        m_arready = 1'b0;
        imem_arvalid = 1'b1; imem_arid = 3'd3; imem_araddr = 32'h4000;
        #1;
        checks++; if (imem_arready !== 1'b1) begin errors++; $display("FAIL bp_first got=%b want=1", imem_arready); end
        tick();
        imem_araddr = 32'h4100;
        dmem_arvalid = 1'b1; dmem_arid = 2'd1; dmem_araddr = 32'h5000;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (imem_arready !== 1'b0 || dmem_arready !== 1'b0) begin errors++; $display("FAIL bp_ready k=%0d got=%b/%b want=0/0", k, imem_arready, dmem_arready); end
            checks++; if (m_arvalid !== 1'b1 || m_araddr !== 32'h4000 || m_arid !== 4'b0011) begin errors++; $display("FAIL bp_stable k=%0d got=%b/%h/%b", k, m_arvalid, m_araddr, m_arid); end
            tick();
        end
        m_arready = 1'b1;
        #1;
        checks++; if (dmem_arready !== 1'b1 || imem_arready !== 1'b0) begin errors++; $display("FAIL bp_release got=%b/%b want=1/0", dmem_arready, imem_arready); end
        tick();
        imem_arvalid = 1'b0; dmem_arvalid = 1'b0;
        checks++; if (m_arvalid !== 1'b1 || m_araddr !== 32'h5000 || m_arid !== 4'b1001) begin errors++; $display("FAIL bp_issue got=%b/%h/%b", m_arvalid, m_araddr, m_arid); end
    endtask

    task automatic test_r_routing();
        imem_rready = 1'b1; dmem_rready = 1'b0;
        m_rvalid = 1'b1; m_rid = 4'b1010; m_rdata = 32'hDEAD_BEEF; m_rresp = 2'd2; m_rlast = 1'b0;
        #1;
        checks++; if (dmem_rvalid !== 1'b1 || imem_rvalid !== 1'b0) begin errors++; $display("FAIL route_valid got=%b/%b want=1/0", dmem_rvalid, imem_rvalid); end
        checks++; if (dmem_rid !== 2'd2 || dmem_rdata !== 32'hDEAD_BEEF || dmem_rresp !== 2'd2) begin errors++; $display("FAIL route_payload got=%0d/%h/%0d", dmem_rid, dmem_rdata, dmem_rresp); end
        checks++; if (m_rready !== 1'b0) begin errors++; $display("FAIL route_rready_low got=%b want=0", m_rready); end
        tick();
        checks++; if (m_rready !== 1'b0 || dmem_rvalid !== 1'b1) begin errors++; $display("FAIL route_hold got=%b/%b want=0/1", m_rready, dmem_rvalid); end
        dmem_rready = 1'b1; imem_rready = 1'b0;
        #1;
        checks++; if (m_rready !== 1'b1) begin errors++; $display("FAIL route_rready_high got=%b want=1", m_rready); end
        tick();
        m_rvalid = 1'b0;
        #1;
        checks++; if (dmem_rvalid !== 1'b0 || imem_rvalid !== 1'b0) begin errors++; $display("FAIL route_idle got=%b/%b want=0/0", dmem_rvalid, imem_rvalid); end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_single_imem();
        test_arbitration();
        test_outstanding();
        test_backpressure();
        test_r_routing();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
